// File: rtl/axi4_mem_arbiter_rr_if.sv
// Single-beat AXI4 bundle (AW/W/B/AR/R, no resp/id) shared by the arbiter's
// requester ports and its memory port.
interface axi4_mem_arbiter_rr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/axi4_mem_arbiter_rr.sv
// Shares one single-beat AXI4 memory port between IFU (s0, read-only) and LSU (s1).
// LSU is preferred, but after MAX_STREAK back-to-back LSU grants a waiting IFU wins.
module axi4_mem_arbiter_rr #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_mem_arbiter_rr_if.slave  s0,
  axi4_mem_arbiter_rr_if.slave  s1,
  axi4_mem_arbiter_rr_if.master m,
  output logic [1:0]            grant,
  output logic [3:0]            streak
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S0_AR = 3'd1;
  localparam logic [2:0] S0_R  = 3'd2;
  localparam logic [2:0] S1_AR = 3'd3;
  localparam logic [2:0] S1_R  = 3'd4;
  localparam logic [2:0] S1_WR = 3'd5;
  localparam logic [2:0] S1_B  = 3'd6;

  localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

  logic [2:0]        state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              req0, req_r1, req_w, s1_win;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0] araddr_sel;
  logic [DATA_W-1:0] rdata_fwd;
  logic              unused_s0;

  // IFU never writes; its write-side inputs are ignored.
  assign unused_s0 = ^{s0.awaddr, s0.awvalid, s0.wdata, s0.wstrb, s0.wvalid, s0.bready};

  assign req0   = s0.arvalid;
  assign req_r1 = s1.arvalid;
  assign req_w  = s1.awvalid & s1.wvalid;
  assign s1_win = (req_w | req_r1) & (~req0 | (streak_q < MAX_S));

  // Handshakes seen on the memory side are already qualified by state.
  assign ar_hs = m.arvalid & m.arready;
  assign r_hs  = m.rvalid  & m.rready;
  assign aw_hs = m.awvalid & m.awready;
  assign w_hs  = m.wvalid  & m.wready;
  assign b_hs  = m.bvalid  & m.bready;

  assign araddr_sel = (state_q == S1_AR) ? s1.araddr : s0.araddr;
  assign rdata_fwd  = m.rdata;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (s1_win) begin
          state_d  = req_w ? S1_WR : S1_AR;
          streak_d = !req0 ? 4'd0 : (streak_q >= MAX_S) ? MAX_S : 4'(streak_q + 4'd1);
        end else if (req0) begin
          state_d  = S0_AR;
          streak_d = 4'd0;
        end
      end
      S0_AR: if (ar_hs) state_d = S0_R;
      S1_AR: if (ar_hs) state_d = S1_R;
      S0_R, S1_R: if (r_hs) state_d = IDLE;
      S1_WR: begin
        // AW and W may finish in either order or together.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = S1_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S1_B: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m.awaddr   = s1.awaddr;
    m.wdata    = s1.wdata;
    m.wstrb    = s1.wstrb;
    m.araddr   = araddr_sel;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.bvalid  = 1'b0;
    s0.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s0.rdata   = rdata_fwd;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.bvalid  = 1'b0;
    s1.arready = 1'b0;
    s1.rvalid  = 1'b0;
    s1.rdata   = rdata_fwd;
    if (!rst) begin
      case (state_q)
        S0_AR: begin
          m.arvalid  = s0.arvalid;
          s0.arready = m.arready;
        end
        S0_R: begin
          m.rready  = s0.rready;
          s0.rvalid = m.rvalid;
        end
        S1_AR: begin
          m.arvalid  = s1.arvalid;
          s1.arready = m.arready;
        end
        S1_R: begin
          m.rready  = s1.rready;
          s1.rvalid = m.rvalid;
        end
        S1_WR: begin
          m.awvalid  = s1.awvalid & ~aw_done_q;
          s1.awready = m.awready & ~aw_done_q;
          m.wvalid   = s1.wvalid & ~w_done_q;
          s1.wready  = m.wready & ~w_done_q;
        end
        S1_B: begin
          m.bready  = s1.bready;
          s1.bvalid = m.bvalid;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    case (state_q)
      S0_AR, S0_R: grant = 2'b01;
      S1_AR, S1_R: grant = 2'b10;
      S1_WR, S1_B: grant = 2'b11;
      default:     grant = 2'b00;
    endcase
  end

  assign streak = streak_q;
endmodule
